// File: rtl/rifl_tx_pkg.sv
// Shared frame typing for the TX path: frame type encoding and the idle filler payload.
package rifl_tx_pkg;

  localparam int TYPE_W = 2;

  typedef enum logic [TYPE_W-1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    CTRL = 2'b10
  } frame_type_t;

  // Wide enough for any payload width in use; callers slice the low bits they need.
  localparam int IDLE_PAYLOAD_MAX_W = 1024;
  localparam logic [IDLE_PAYLOAD_MAX_W-1:0] IDLE_PAYLOAD = '0;

endpackage

// File: rtl/tx_slot_timer.sv
// Slot counter for the TX scheduler: counts 0..RATIO-1 and flags the last cycle of each slot.
module tx_slot_timer #(
  parameter int RATIO = 4,
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] slot_cnt,
  output logic             decision
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(RATIO - 1);

  // With RATIO==1 LAST is 0, so the counter sits at 0 and every cycle decides.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt <= '0;
    end else if (slot_cnt == LAST) begin
      slot_cnt <= '0;
    end else begin
      slot_cnt <= slot_cnt + CNT_W'(1);
    end
  end

  assign decision = (slot_cnt == LAST);

endmodule

// File: rtl/tx_frame_scheduler.sv
// Picks control, data or idle once per converter period and holds that frame for RATIO cycles.
module tx_frame_scheduler
  import rifl_tx_pkg::*;
#(
  parameter int DWIDTH_IN      = 256,
  parameter int DWIDTH_OUT     = 64,
  parameter int MAX_CTRL_BURST = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DWIDTH_IN-3:0]  data_tdata,
  input  logic                  data_tvalid,
  output logic                  data_tready,
  input  logic                  ctrl_req,
  input  logic [DWIDTH_IN-3:0]  ctrl_payload,
  output logic                  ctrl_ack,
  input  logic                  pause,
  output logic [DWIDTH_IN-1:0]  frame_out,
  output logic [TYPE_W-1:0]     frame_type,
  output logic                  slot_start
);

  localparam int RATIO    = (DWIDTH_IN / DWIDTH_OUT > 1) ? DWIDTH_IN / DWIDTH_OUT : 1;
  localparam int PAY_W    = DWIDTH_IN - TYPE_W;
  localparam int STREAK_W = $clog2(MAX_CTRL_BURST + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_CTRL_BURST);
  localparam logic [PAY_W-1:0]    IDLE_PAY   = IDLE_PAYLOAD[PAY_W-1:0];

  logic                      decision;
  logic [$clog2(RATIO > 1 ? RATIO : 2)-1:0] slot_cnt;
  logic                      data_ok;
  logic                      win_ctrl;
  logic                      win_data;
  logic [STREAK_W-1:0]       ctrl_streak;

  tx_slot_timer #(
    .RATIO (RATIO)
  ) u_slot_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .slot_cnt (slot_cnt),
    .decision (decision)
  );

  // Handshake: a source transfers exactly when its valid/req is high and the
  // matching ready/ack is high in the same cycle; both are decision-cycle only.
  assign data_ok  = data_tvalid && !pause;
  assign win_ctrl = ctrl_req && ((ctrl_streak < STREAK_MAX) || !data_ok);
  assign win_data = !win_ctrl && data_ok;

  assign ctrl_ack    = rst_n && decision && win_ctrl;
  assign data_tready = rst_n && decision && win_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_streak <= '0;
      frame_out   <= {IDLE, IDLE_PAY};
      frame_type  <= IDLE;
      slot_start  <= 1'b0;
    end else begin
      slot_start <= decision;
      if (decision) begin
        if (win_ctrl) begin
          frame_out  <= {CTRL, ctrl_payload};
          frame_type <= CTRL;
          if (ctrl_streak != STREAK_MAX) begin
            ctrl_streak <= ctrl_streak + STREAK_W'(1);
          end
        end else if (win_data) begin
          frame_out   <= {DATA, data_tdata};
          frame_type  <= DATA;
          ctrl_streak <= '0;
        end else begin
          frame_out   <= {IDLE, IDLE_PAY};
          frame_type  <= IDLE;
          ctrl_streak <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed and randomized bench for tx_frame_scheduler against a slot-level reference model.
module tb_tx_frame_scheduler;

  localparam int DW        = 256;
  localparam int PW        = DW - 2;
  localparam int RATIO     = 4;
  localparam int MAX_BURST = 2;
  localparam int NDW       = 64;
  localparam int NPW       = NDW - 2;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_DATA = 2'b01;
  localparam logic [1:0] T_CTRL = 2'b10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- wide DUT ----------------
  logic [PW-1:0] data_tdata;
  logic          data_tvalid;
  logic          data_tready;
  logic          ctrl_req;
  logic [PW-1:0] ctrl_payload;
  logic          ctrl_ack;
  logic          pause;
  logic [DW-1:0] frame_out;
  logic [1:0]    frame_type;
  logic          slot_start;

  tx_frame_scheduler #(
    .DWIDTH_IN      (DW),
    .DWIDTH_OUT     (64),
    .MAX_CTRL_BURST (MAX_BURST)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_tdata   (data_tdata),
    .data_tvalid  (data_tvalid),
    .data_tready  (data_tready),
    .ctrl_req     (ctrl_req),
    .ctrl_payload (ctrl_payload),
    .ctrl_ack     (ctrl_ack),
    .pause        (pause),
    .frame_out    (frame_out),
    .frame_type   (frame_type),
    .slot_start   (slot_start)
  );

  // ---------------- narrow DUT (RATIO == 1) ----------------
  logic [NPW-1:0] n_data_tdata;
  logic           n_data_tvalid;
  logic           n_data_tready;
  logic           n_ctrl_req;
  logic [NPW-1:0] n_ctrl_payload;
  logic           n_ctrl_ack;
  logic           n_pause;
  logic [NDW-1:0] n_frame_out;
  logic [1:0]     n_frame_type;
  logic           n_slot_start;

  tx_frame_scheduler #(
    .DWIDTH_IN      (NDW),
    .DWIDTH_OUT     (NDW),
    .MAX_CTRL_BURST (MAX_BURST)
  ) u_dut_n (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_tdata   (n_data_tdata),
    .data_tvalid  (n_data_tvalid),
    .data_tready  (n_data_tready),
    .ctrl_req     (n_ctrl_req),
    .ctrl_payload (n_ctrl_payload),
    .ctrl_ack     (n_ctrl_ack),
    .pause        (n_pause),
    .frame_out    (n_frame_out),
    .frame_type   (n_frame_type),
    .slot_start   (n_slot_start)
  );

  // ---------------- scoreboard / model state ----------------
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] cur_exp;
  logic [1:0]    obs_log[$];
  int unsigned   m_k;
  int unsigned   m_streak;
  bit            m_dec;
  bit            m_win_ctrl;
  logic [DW-1:0] m_next;
  bit            acc_data;
  bit            acc_ctrl;
  bit            obs_tready;
  bit            obs_ack;
  bit            rand_mode;
  bit            ctrl_hold;
  int unsigned   data_seq;
  logic [1:0]    exp_seq[6];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] rand_payload();
    logic [DW-1:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    return r[PW-1:0];
  endfunction

  // Reference model: a slot is RATIO non-reset cycles long, the last one decides.
  task automatic eval_cycle();
    bit ok, c, d, exp_ss;
    m_dec = (rst_n === 1'b1) && ((m_k % RATIO) == RATIO - 1);
    ok = data_tvalid && !pause;
    c  = ctrl_req && ((m_streak < MAX_BURST) || !ok);
    d  = !c && ok;
    m_win_ctrl = c;
    acc_ctrl = m_dec && c;
    acc_data = m_dec && d;
    if (c)      m_next = {T_CTRL, ctrl_payload};
    else if (d) m_next = {T_DATA, data_tdata};
    else        m_next = {T_IDLE, PW'(0)};
    check("ctrl_ack", DW'(ctrl_ack), DW'(acc_ctrl));
    check("data_tready", DW'(data_tready), DW'(acc_data));
    exp_ss = (m_k > 0) && ((m_k % RATIO) == 0);
    check("slot_start", DW'(slot_start), DW'(exp_ss));
    if (exp_ss) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL exp_q_empty: observed %0d expected 1", exp_q.size());
      end
      if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
    end
    check("frame_out", frame_out, cur_exp);
    check("frame_type", DW'(frame_type), DW'(cur_exp[DW-1:DW-2]));
    if (slot_start === 1'b1) obs_log.push_back(frame_type);
    obs_tready = (data_tready === 1'b1);
    obs_ack    = (ctrl_ack === 1'b1);
  endtask

  task automatic model_update();
    if (rst_n !== 1'b1) begin
      m_k      = 0;
      m_streak = 0;
      cur_exp  = {T_IDLE, PW'(0)};
      exp_q.delete();
    end else begin
      if (m_dec) begin
        exp_q.push_back(m_next);
        if (m_win_ctrl) m_streak = (m_streak < MAX_BURST) ? m_streak + 1 : MAX_BURST;
        else            m_streak = 0;
      end
      m_k++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_sources();
    if (acc_data) begin
      data_seq++;
      data_tdata = rand_mode ? rand_payload() : PW'(data_seq);
    end
    if (acc_ctrl) begin
      if (ctrl_hold) ctrl_payload = rand_payload();
      else           ctrl_req = 1'b0;
    end
    if (rand_mode) begin
      if (!ctrl_req && $urandom_range(0, 3) == 0) begin
        ctrl_req     = 1'b1;
        ctrl_payload = rand_payload();
      end
      if (!data_tvalid && $urandom_range(0, 1) == 1) begin
        data_tvalid = 1'b1;
        data_tdata  = rand_payload();
      end else if (acc_data && $urandom_range(0, 3) == 0) begin
        data_tvalid = 1'b0;
      end
      pause = ($urandom_range(0, 4) == 0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    eval_cycle();
    @(posedge clk);
    model_update();
    #1;
    drive_sources();
  endtask

  task automatic align(input int unsigned pos);
    int n;
    n = 0;
    while ((m_k % RATIO) != pos && n < 2 * RATIO) begin
      tick();
      n++;
    end
    check("align", DW'(m_k % RATIO), DW'(pos));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic [NPW-1:0] n_prev;

    rst_n = 1'b0;
    data_tdata = '0; data_tvalid = 1'b0; ctrl_req = 1'b0; ctrl_payload = '0; pause = 1'b0;
    n_data_tdata = '0; n_data_tvalid = 1'b0; n_ctrl_req = 1'b0; n_ctrl_payload = '0; n_pause = 1'b0;
    rand_mode = 1'b0; ctrl_hold = 1'b0; data_seq = 0;
    m_k = 0; m_streak = 0; cur_exp = {T_IDLE, PW'(0)};
    acc_data = 1'b0; acc_ctrl = 1'b0;
    exp_seq = '{T_CTRL, T_CTRL, T_DATA, T_CTRL, T_CTRL, T_DATA};
    @(posedge clk);
    #1;
    tick();
    tick();

    // 1: idle after reset release
    rst_n = 1'b1;
    repeat (13) tick();

    // 2: sequential data payloads 0,1,2,...
    align(1);
    data_seq = 0; data_tdata = PW'(0); data_tvalid = 1'b1;
    repeat (14) tick();
    data_tvalid = 1'b0;
    repeat (6) tick();

    // 3: control burst limit against continuous data
    align(1);
    ctrl_hold = 1'b1; ctrl_req = 1'b1; ctrl_payload = rand_payload(); data_tvalid = 1'b1;
    obs_log.delete();
    repeat (24) tick();
    check("burst_count", DW'(obs_log.size()), DW'(6));
    for (int i = 0; i < 6; i++) begin
      if (i < obs_log.size()) check("burst_seq", DW'(obs_log[i]), DW'(exp_seq[i]));
    end
    ctrl_hold = 1'b0; ctrl_req = 1'b0;

    // 4: pause blocks data but not control
    align(1);
    pause = 1'b1; data_tvalid = 1'b1;
    obs_log.delete();
    repeat (8) tick();
    check("pause_frames", DW'(obs_log.size()), DW'(2));
    foreach (obs_log[i]) check("pause_idle", DW'(obs_log[i]), DW'(T_IDLE));
    ctrl_req = 1'b1; ctrl_payload = rand_payload();
    lat = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (obs_ack) begin lat = i; break; end
    end
    check("pause_ctrl_acked", DW'(lat >= 0), DW'(1));
    align(1);
    pause = 1'b0;
    obs_log.delete();
    repeat (4) tick();
    check("unpause_count", DW'(obs_log.size()), DW'(1));
    if (obs_log.size() > 0) check("unpause_data", DW'(obs_log[0]), DW'(T_DATA));

    // 5: reset mid-slot of a data frame
    align(2);
    check("pre_reset_type", DW'(frame_type), DW'(T_DATA));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("reset_idle_type", DW'(frame_type), DW'(T_IDLE));
    check("reset_no_start", DW'(slot_start), DW'(0));
    lat = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (obs_tready) begin lat = i; break; end
    end
    check("reset_latency", DW'(lat), DW'(RATIO - 1));

    // randomized traffic
    rand_mode = 1'b1;
    repeat (400) tick();
    rand_mode = 1'b0; ctrl_req = 1'b0; data_tvalid = 1'b0; pause = 1'b0;
    repeat (8) tick();

    // 6: RATIO == 1, back-to-back data
    n_data_tvalid = 1'b1;
    n_data_tdata  = NPW'(100);
    n_prev = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("n_tready", DW'(n_data_tready), DW'(1));
      check("n_ack", DW'(n_ctrl_ack), DW'(0));
      check("n_slot_start", DW'(n_slot_start), DW'(1));
      if (i > 0) begin
        check("n_frame_out", DW'(n_frame_out), DW'({T_DATA, n_prev}));
        check("n_frame_type", DW'(n_frame_type), DW'(T_DATA));
      end
      n_prev = n_data_tdata;
      @(posedge clk);
      #1;
      n_data_tdata = NPW'(101 + i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
